// File: rtl/pwm_duty_meas.sv
// pwm_duty_meas: decodes a 12-bit-period PWM line into duty, signed speed and a stuck flag.
// Optional 3-tap majority glitch filter after the synchronizer: define PWM_MEAS_GLITCH_FILTER_EN.
module pwm_duty_meas #(
   parameter bit INVERT  = 1'b0,
   parameter int TMO_CYC = 8192
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pwm_in,
   output logic [11:0] duty,
   output logic [11:0] spd,
   output logic        vld,
   output logic        stuck
);

   localparam logic [13:0] TMO_LAST = 14'(TMO_CYC - 1);
   localparam logic [11:0] MID      = 12'h800;

   typedef enum logic [1:0] {S_WAIT, S_HIGH, S_LOW} state_t;

   logic [1:0] sync_q;
   logic       pwm_sync;
   logic       pwm_s;
   logic       pwm_d;
   logic       rise_q, fall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b00;
      else        sync_q <= {sync_q[0], pwm_in};
   end
   assign pwm_sync = sync_q[1];

`ifdef PWM_MEAS_GLITCH_FILTER_EN
   logic [2:0] tap_q;
   logic       filt_q;

   // Registered majority of three taps: single-cycle pulses of either level vanish.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap_q  <= 3'b000;
         filt_q <= 1'b0;
      end else begin
         tap_q  <= {tap_q[1:0], pwm_sync};
         filt_q <= (tap_q[0] & tap_q[1]) | (tap_q[0] & tap_q[2]) | (tap_q[1] & tap_q[2]);
      end
   end
   assign pwm_s = filt_q;
`else
   assign pwm_s = pwm_sync;
`endif

   // Edge-detect stage; pwm_d is the level aligned with the registered edge pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_d  <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         pwm_d  <= pwm_s;
         rise_q <= pwm_s & ~pwm_d;
         fall_q <= ~pwm_s & pwm_d;
      end
   end

   state_t      st, st_n;
   logic [11:0] hcnt, hcnt_n;
   logic [11:0] hlat, hlat_n;
   logic [13:0] tcnt, tcnt_n;
   logic [11:0] duty_n, spd_n;
   logic        vld_n, stuck_n;
   logic        any_edge, tmo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st    <= S_WAIT;
         hcnt  <= 12'h000;
         hlat  <= 12'h000;
         tcnt  <= 14'h0000;
         duty  <= MID;
         spd   <= 12'h000;
         vld   <= 1'b0;
         stuck <= 1'b0;
      end else begin
         st    <= st_n;
         hcnt  <= hcnt_n;
         hlat  <= hlat_n;
         tcnt  <= tcnt_n;
         duty  <= duty_n;
         spd   <= spd_n;
         vld   <= vld_n;
         stuck <= stuck_n;
      end
   end

   always_comb begin
      st_n     = st;
      hcnt_n   = hcnt;
      hlat_n   = hlat;
      duty_n   = duty;
      stuck_n  = stuck;
      vld_n    = 1'b0;
      any_edge = rise_q | fall_q;
      tmo      = !any_edge && (tcnt == TMO_LAST);

      if (any_edge || tmo) tcnt_n = 14'h0000;
      else                 tcnt_n = tcnt + 14'd1;

      case (st)
         S_WAIT: begin
            if (rise_q) begin
               st_n   = S_HIGH;
               hcnt_n = 12'd1;
            end
         end
         S_HIGH: begin
            if (fall_q) begin
               st_n   = S_LOW;
               hlat_n = hcnt;
            end else if (pwm_d && hcnt != 12'hFFF) begin
               hcnt_n = hcnt + 12'd1;
            end
         end
         S_LOW: begin
            if (rise_q) begin
               st_n    = S_HIGH;
               hcnt_n  = 12'd1;
               duty_n  = hlat;
               stuck_n = 1'b0;
               vld_n   = 1'b1;
            end
         end
         default: st_n = S_WAIT;
      endcase

      // tmo already excludes an edge this cycle, so the edge always wins.
      if (tmo) begin
         st_n    = S_WAIT;
         duty_n  = pwm_d ? 12'hFFF : 12'h000;
         stuck_n = 1'b1;
         vld_n   = 1'b1;
      end

      spd_n = INVERT ? (MID - duty_n) : (duty_n - MID);
   end

endmodule
